// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one 8-bit ALU between two requesters. Arbitrates,
//                latches the winner's operands for EXEC_CYCLES cycles, then
//                returns the result on one response channel tagged with the
//                requester id.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int ARB_MODE    = 0,   // 0 = round-robin, 1 = req0 always wins
    parameter int EXEC_CYCLES = 1    // 1..15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [7:0] req0_a_i,
    input  logic [7:0] req0_b_i,
    input  logic [2:0] req0_op_i,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic [7:0] req1_a_i,
    input  logic [7:0] req1_b_i,
    input  logic [2:0] req1_op_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_res_o,
    output logic       rsp_id_o,
    output logic       busy_o
);

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] op_code;
    logic       op_id;
    logic       last_ptr;
    logic [3:0] cnt;
    logic       grant0;
    logic       grant1;
    logic       accept;
    logic [7:0] alu_res;

    // Arbitration: req0 wins when alone, in fixed-priority mode, or when req1 was served last.
    always_comb begin
        grant0 = req0_valid_i && (!req1_valid_i || (ARB_MODE == 1) || last_ptr);
        grant1 = req1_valid_i && !grant0;
    end

    // Ready is only offered in IDLE and never while reset is asserted.
    always_comb begin
        req0_ready_o = grant0 && (state == IDLE) && rst_ni;
        req1_ready_o = grant1 && (state == IDLE) && rst_ni;
        accept       = req0_ready_o || req1_ready_o;
    end

    // Shared ALU, fed only from the latched operand registers.
    always_comb begin
        alu_res = 8'h00;
        case (op_code)
            3'b000:  alu_res = op_a + op_b;
            3'b001:  alu_res = op_a - op_b;
            3'b010:  alu_res = op_a & op_b;
            3'b011:  alu_res = op_a | op_b;
            3'b100:  alu_res = op_a ^ op_b;
            3'b101:  alu_res = op_a << op_b;   // shift >= 8 naturally yields 0
            3'b110:  alu_res = op_a >> op_b;
            default: alu_res = 8'h00;
        endcase
    end

    // Next-state logic for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    if (cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latch, execution counter, response registers and busy flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_a        <= 8'h00;
            op_b        <= 8'h00;
            op_code     <= 3'b000;
            op_id       <= 1'b0;
            last_ptr    <= 1'b1;
            cnt         <= 4'd0;
            rsp_valid_o <= 1'b0;
            rsp_res_o   <= 8'h00;
            rsp_id_o    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            busy_o <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a     <= req1_ready_o ? req1_a_i  : req0_a_i;
                        op_b     <= req1_ready_o ? req1_b_i  : req0_b_i;
                        op_code  <= req1_ready_o ? req1_op_i : req0_op_i;
                        op_id    <= req1_ready_o;
                        last_ptr <= req1_ready_o;
                        cnt      <= CNT_LOAD;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_res_o   <= alu_res;
                        rsp_id_o    <= op_id;
                        rsp_valid_o <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) rsp_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
